// File: rtl/apu_share_xbar.sv
// apu_share_xbar
//   Shares NAPUS auxiliary processing units (FPU/LNU) among NCPUS cores.
//
//   Downstream: eligible core requests (req=1 and below the per-core
//   outstanding limit) are walked round-robin from ds_ptr. Each one is placed
//   on the lowest-index ready APU not yet taken this cycle. Acks and APU
//   valids are combinational, so the transfer completes in the same cycle.
//   The APU-side tag is {core index, core tag}.
//
//   Upstream: each core owns one registered return slot. When the slot is free,
//   it takes one APU result addressed to that core, chosen round-robin from
//   us_ptr[core], and presents it one cycle after the APU ack.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   cpu_req_ds_i / cpu_ack_ds_o      core request / accept (per core)
//   cpu_arga_i, cpu_argb_i, cpu_op_i,
//   cpu_flags_ds_i, cpu_tag_ds_i     core request payload (flattened per core)
//   cpu_valid_us_o / cpu_ready_us_i  result valid / core accepts result
//   cpu_result_o, cpu_flags_us_o,
//   cpu_tag_us_o                     registered result payload per core
//   apu_valid_ds_o / apu_ready_ds_i  operation valid / APU accepts
//   apu_arga_o, apu_argb_o, apu_op_o,
//   apu_flags_ds_o, apu_tag_ds_o     operation payload per APU
//   apu_req_us_i / apu_ack_us_o      APU has result / result taken
//   apu_result_i, apu_flags_us_i,
//   apu_tag_us_i                     APU result payload per APU
module apu_share_xbar #(
    parameter int NCPUS    = 4,
    parameter int NAPUS    = 2,
    parameter int WARG     = 32,
    parameter int WRESULT  = 32,
    parameter int WOP      = 4,
    parameter int NDSFLAGS = 2,
    parameter int NUSFLAGS = 9,
    parameter int WCPUTAG  = 5,
    parameter int MAXOUT   = 2,
    parameter int CPUIDW   = (NCPUS > 1) ? $clog2(NCPUS) : 1,
    parameter int WAPUTAG  = WCPUTAG + CPUIDW
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NCPUS-1:0]            cpu_req_ds_i,
    output logic [NCPUS-1:0]            cpu_ack_ds_o,
    input  logic [NCPUS*WARG-1:0]       cpu_arga_i,
    input  logic [NCPUS*WARG-1:0]       cpu_argb_i,
    input  logic [NCPUS*WOP-1:0]        cpu_op_i,
    input  logic [NCPUS*NDSFLAGS-1:0]   cpu_flags_ds_i,
    input  logic [NCPUS*WCPUTAG-1:0]    cpu_tag_ds_i,
    output logic [NCPUS-1:0]            cpu_valid_us_o,
    input  logic [NCPUS-1:0]            cpu_ready_us_i,
    output logic [NCPUS*WRESULT-1:0]    cpu_result_o,
    output logic [NCPUS*NUSFLAGS-1:0]   cpu_flags_us_o,
    output logic [NCPUS*WCPUTAG-1:0]    cpu_tag_us_o,
    output logic [NAPUS-1:0]            apu_valid_ds_o,
    input  logic [NAPUS-1:0]            apu_ready_ds_i,
    output logic [NAPUS*WARG-1:0]       apu_arga_o,
    output logic [NAPUS*WARG-1:0]       apu_argb_o,
    output logic [NAPUS*WOP-1:0]        apu_op_o,
    output logic [NAPUS*NDSFLAGS-1:0]   apu_flags_ds_o,
    output logic [NAPUS*WAPUTAG-1:0]    apu_tag_ds_o,
    input  logic [NAPUS-1:0]            apu_req_us_i,
    output logic [NAPUS-1:0]            apu_ack_us_o,
    input  logic [NAPUS*WRESULT-1:0]    apu_result_i,
    input  logic [NAPUS*NUSFLAGS-1:0]   apu_flags_us_i,
    input  logic [NAPUS*WAPUTAG-1:0]    apu_tag_us_i
);

    localparam int APUIDW = (NAPUS > 1) ? $clog2(NAPUS) : 1;
    localparam int CNTW   = $clog2(MAXOUT + 1);

    // ------------------------------------------------------------------
    // Downstream allocation
    // ------------------------------------------------------------------
    logic [CPUIDW-1:0]             ds_ptr;
    logic [CPUIDW-1:0]             ds_ptr_nxt;
    logic [CPUIDW-1:0]             ds_last;
    logic [CPUIDW-1:0]             ds_cidx;
    logic                          ds_any;
    logic                          ds_found;
    logic [NCPUS-1:0]              eligible;
    logic [NCPUS-1:0]              cpu_grant;
    logic [NAPUS-1:0]              apu_busy;
    logic [NAPUS-1:0][CPUIDW-1:0]  apu_src;
    logic [NCPUS-1:0][CNTW-1:0]    out_cnt;
    logic [NCPUS-1:0]              us_hs;

    assign us_hs = cpu_valid_us_o & cpu_ready_us_i;

    // A core sitting at the limit may still issue in a cycle where one of its
    // results is being retired, so the counter never exceeds MAXOUT.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NCPUS; i++) begin
            eligible[i] = !rst_i && cpu_req_ds_i[i] &&
                          ((int'(out_cnt[i]) < MAXOUT) || us_hs[i]);
        end
    end

    always_comb begin
        apu_busy  = '0;
        apu_src   = '0;
        cpu_grant = '0;
        ds_any    = 1'b0;
        ds_last   = '0;
        ds_cidx   = '0;
        ds_found  = 1'b0;
        for (int unsigned k = 0; k < NCPUS; k++) begin
            ds_cidx  = CPUIDW'((32'(ds_ptr) + k) % NCPUS);
            ds_found = 1'b0;
            if (eligible[ds_cidx]) begin
                for (int unsigned j = 0; j < NAPUS; j++) begin
                    if (!ds_found && apu_ready_ds_i[j] && !apu_busy[j]) begin
                        ds_found           = 1'b1;
                        apu_busy[j]        = 1'b1;
                        apu_src[j]         = ds_cidx;
                        cpu_grant[ds_cidx] = 1'b1;
                        ds_any             = 1'b1;
                        ds_last            = ds_cidx;
                    end
                end
            end
        end
        ds_ptr_nxt = ds_any ? CPUIDW'((32'(ds_last) + 1) % NCPUS) : ds_ptr;
    end

    assign cpu_ack_ds_o   = cpu_grant;
    assign apu_valid_ds_o = apu_busy;

    always_comb begin
        apu_arga_o     = '0;
        apu_argb_o     = '0;
        apu_op_o       = '0;
        apu_flags_ds_o = '0;
        apu_tag_ds_o   = '0;
        for (int unsigned j = 0; j < NAPUS; j++) begin
            if (apu_busy[j]) begin
                apu_arga_o[j*WARG +: WARG]             = cpu_arga_i[apu_src[j]*WARG +: WARG];
                apu_argb_o[j*WARG +: WARG]             = cpu_argb_i[apu_src[j]*WARG +: WARG];
                apu_op_o[j*WOP +: WOP]                 = cpu_op_i[apu_src[j]*WOP +: WOP];
                apu_flags_ds_o[j*NDSFLAGS +: NDSFLAGS] = cpu_flags_ds_i[apu_src[j]*NDSFLAGS +: NDSFLAGS];
                apu_tag_ds_o[j*WAPUTAG +: WAPUTAG]     = {apu_src[j], cpu_tag_ds_i[apu_src[j]*WCPUTAG +: WCPUTAG]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ds_ptr <= '0;
        end else begin
            ds_ptr <= ds_ptr_nxt;
        end
    end

    // Outstanding counters; decrement saturates at 0 so results of operations
    // dropped by a reset cannot wrap the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NCPUS; i++) begin
                if (cpu_grant[i] && !us_hs[i]) begin
                    out_cnt[i] <= out_cnt[i] + CNTW'(1);
                end else if (!cpu_grant[i] && us_hs[i] && (out_cnt[i] != '0)) begin
                    out_cnt[i] <= out_cnt[i] - CNTW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Upstream return
    // ------------------------------------------------------------------
    logic [NCPUS-1:0][APUIDW-1:0]  us_ptr;
    logic [NCPUS-1:0][APUIDW-1:0]  us_win;
    logic [NCPUS-1:0]              us_free;
    logic [NCPUS-1:0]              us_take;
    logic [APUIDW-1:0]             us_aidx;

    always_comb begin
        us_free      = '0;
        us_take      = '0;
        us_win       = '0;
        us_aidx      = '0;
        apu_ack_us_o = '0;
        for (int unsigned i = 0; i < NCPUS; i++) begin
            us_free[i] = !cpu_valid_us_o[i] || cpu_ready_us_i[i];
            for (int unsigned k = 0; k < NAPUS; k++) begin
                us_aidx = APUIDW'((32'(us_ptr[i]) + k) % NAPUS);
                if (!us_take[i] && !rst_i && us_free[i] && apu_req_us_i[us_aidx] &&
                    (apu_tag_us_i[us_aidx*WAPUTAG + WCPUTAG +: CPUIDW] == CPUIDW'(i))) begin
                    us_take[i] = 1'b1;
                    us_win[i]  = us_aidx;
                end
            end
            if (us_take[i]) begin
                apu_ack_us_o[us_win[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpu_valid_us_o <= '0;
            cpu_result_o   <= '0;
            cpu_flags_us_o <= '0;
            cpu_tag_us_o   <= '0;
            us_ptr         <= '0;
        end else begin
            for (int unsigned i = 0; i < NCPUS; i++) begin
                if (us_take[i]) begin
                    cpu_valid_us_o[i]                    <= 1'b1;
                    cpu_result_o[i*WRESULT +: WRESULT]   <= apu_result_i[us_win[i]*WRESULT +: WRESULT];
                    cpu_flags_us_o[i*NUSFLAGS +: NUSFLAGS] <= apu_flags_us_i[us_win[i]*NUSFLAGS +: NUSFLAGS];
                    cpu_tag_us_o[i*WCPUTAG +: WCPUTAG]   <= apu_tag_us_i[us_win[i]*WAPUTAG +: WCPUTAG];
                    us_ptr[i]                            <= APUIDW'((32'(us_win[i]) + 1) % NAPUS);
                end else if (us_free[i]) begin
                    cpu_valid_us_o[i] <= 1'b0;
                end
            end
        end
    end

    // A returned tag naming a nonexistent core is never acked and would stall
    // that APU forever; flag it in simulation.
    for (genvar j = 0; j < NAPUS; j++) begin : g_tag_chk
        assert property (@(posedge clk_i) disable iff (rst_i)
            apu_req_us_i[j] |-> (int'(apu_tag_us_i[j*WAPUTAG + WCPUTAG +: CPUIDW]) < NCPUS));
    end

endmodule

// File: tb/tb_apu_share_xbar.sv
// Directed bench for apu_share_xbar with default parameters
// (4 cores, 2 APUs, 5-bit core tags, MAXOUT = 2).
module tb_apu_share_xbar;

    localparam int NC = 4;
    localparam int NA = 2;
    localparam int WA = 32;
    localparam int WR = 32;
    localparam int WO = 4;
    localparam int DF = 2;
    localparam int UF = 9;
    localparam int CT = 5;
    localparam int AT = 7;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NC-1:0]       cpu_req_ds_i;
    logic [NC-1:0]       cpu_ack_ds_o;
    logic [NC*WA-1:0]    cpu_arga_i;
    logic [NC*WA-1:0]    cpu_argb_i;
    logic [NC*WO-1:0]    cpu_op_i;
    logic [NC*DF-1:0]    cpu_flags_ds_i;
    logic [NC*CT-1:0]    cpu_tag_ds_i;
    logic [NC-1:0]       cpu_valid_us_o;
    logic [NC-1:0]       cpu_ready_us_i;
    logic [NC*WR-1:0]    cpu_result_o;
    logic [NC*UF-1:0]    cpu_flags_us_o;
    logic [NC*CT-1:0]    cpu_tag_us_o;
    logic [NA-1:0]       apu_valid_ds_o;
    logic [NA-1:0]       apu_ready_ds_i;
    logic [NA*WA-1:0]    apu_arga_o;
    logic [NA*WA-1:0]    apu_argb_o;
    logic [NA*WO-1:0]    apu_op_o;
    logic [NA*DF-1:0]    apu_flags_ds_o;
    logic [NA*AT-1:0]    apu_tag_ds_o;
    logic [NA-1:0]       apu_req_us_i;
    logic [NA-1:0]       apu_ack_us_o;
    logic [NA*WR-1:0]    apu_result_i;
    logic [NA*UF-1:0]    apu_flags_us_i;
    logic [NA*AT-1:0]    apu_tag_us_i;

    int checks = 0;
    int errors = 0;

    apu_share_xbar #(
        .NCPUS(NC), .NAPUS(NA), .WARG(WA), .WRESULT(WR), .WOP(WO),
        .NDSFLAGS(DF), .NUSFLAGS(UF), .WCPUTAG(CT), .MAXOUT(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_ds_i(cpu_req_ds_i), .cpu_ack_ds_o(cpu_ack_ds_o),
        .cpu_arga_i(cpu_arga_i), .cpu_argb_i(cpu_argb_i), .cpu_op_i(cpu_op_i),
        .cpu_flags_ds_i(cpu_flags_ds_i), .cpu_tag_ds_i(cpu_tag_ds_i),
        .cpu_valid_us_o(cpu_valid_us_o), .cpu_ready_us_i(cpu_ready_us_i),
        .cpu_result_o(cpu_result_o), .cpu_flags_us_o(cpu_flags_us_o),
        .cpu_tag_us_o(cpu_tag_us_o),
        .apu_valid_ds_o(apu_valid_ds_o), .apu_ready_ds_i(apu_ready_ds_i),
        .apu_arga_o(apu_arga_o), .apu_argb_o(apu_argb_o), .apu_op_o(apu_op_o),
        .apu_flags_ds_o(apu_flags_ds_o), .apu_tag_ds_o(apu_tag_ds_o),
        .apu_req_us_i(apu_req_us_i), .apu_ack_us_o(apu_ack_us_o),
        .apu_result_i(apu_result_i), .apu_flags_us_i(apu_flags_us_i),
        .apu_tag_us_i(apu_tag_us_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // 1 time unit later, well clear of either clock edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_us(input int j, input logic r, input logic [AT-1:0] tag,
                          input logic [WR-1:0] res);
        apu_req_us_i[j]              = r;
        apu_tag_us_i[j*AT +: AT]     = tag;
        apu_result_i[j*WR +: WR]     = res;
        apu_flags_us_i[j*UF +: UF]   = {2'b00, tag};
    endtask

    task automatic clear_inputs();
        cpu_req_ds_i   = '0;
        apu_ready_ds_i = '0;
        apu_req_us_i   = '0;
        cpu_ready_us_i = '1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        apu_tag_us_i   = '0;
        apu_result_i   = '0;
        apu_flags_us_i = '0;
        for (int i = 0; i < NC; i++) begin
            cpu_arga_i[i*WA +: WA]     = 32'h0000_1000 + 32'(i);
            cpu_argb_i[i*WA +: WA]     = 32'h0000_2000 + 32'(i);
            cpu_op_i[i*WO +: WO]       = 4'(i + 8);
            cpu_flags_ds_i[i*DF +: DF] = 2'(i);
            cpu_tag_ds_i[i*CT +: CT]   = 5'(i + 1);
        end

        // Reset held with everything requesting: nothing may be granted.
        cpu_req_ds_i   = '1;
        apu_ready_ds_i = '1;
        cpu_ready_us_i = '1;
        set_us(0, 1'b1, 7'h01, 32'h1);
        set_us(1, 1'b1, 7'h22, 32'h2);
        tick();
        settle();
        chk("rst_ack_ds",   64'(cpu_ack_ds_o),   64'h0);
        chk("rst_valid_ds", 64'(apu_valid_ds_o), 64'h0);
        chk("rst_ack_us",   64'(apu_ack_us_o),   64'h0);
        chk("rst_valid_us", 64'(cpu_valid_us_o), 64'h0);
        chk("rst_result",   64'(|cpu_result_o),  64'h0);
        chk("rst_tag_us",   64'(cpu_tag_us_o),   64'h0);
        do_reset();

        // Round-robin allocation of four requesters onto two APUs.
        cpu_req_ds_i   = 4'b1111;
        apu_ready_ds_i = 2'b11;
        settle();
        chk("rr0_ack",    64'(cpu_ack_ds_o),   64'h3);
        chk("rr0_valid",  64'(apu_valid_ds_o), 64'h3);
        chk("rr0_tag0",   64'(apu_tag_ds_o[0 +: AT]),  64'h01);
        chk("rr0_tag1",   64'(apu_tag_ds_o[AT +: AT]), 64'h22);
        chk("rr0_arga1",  64'(apu_arga_o[WA +: WA]),   64'h1001);
        chk("rr0_op1",    64'(apu_op_o[WO +: WO]),     64'h9);
        tick();
        cpu_req_ds_i = 4'b1100;
        settle();
        chk("rr1_ack",    64'(cpu_ack_ds_o),   64'hC);
        chk("rr1_tag0",   64'(apu_tag_ds_o[0 +: AT]),  64'h43);
        chk("rr1_tag1",   64'(apu_tag_ds_o[AT +: AT]), 64'h64);
        chk("rr1_argb0",  64'(apu_argb_o[0 +: WA]),    64'h2002);
        chk("rr1_flags1", 64'(apu_flags_ds_o[DF +: DF]), 64'h3);
        tick();
        // Pointer back at 0: core 1 must beat core 3 for the single ready APU.
        cpu_req_ds_i   = 4'b1010;
        apu_ready_ds_i = 2'b10;
        settle();
        chk("rr2_ack",    64'(cpu_ack_ds_o),   64'h2);
        chk("rr2_valid",  64'(apu_valid_ds_o), 64'h2);
        chk("rr2_tag1",   64'(apu_tag_ds_o[AT +: AT]), 64'h22);
        tick();
        do_reset();

        // Outstanding limit on core 1.
        cpu_req_ds_i   = 4'b0010;
        apu_ready_ds_i = 2'b11;
        settle();
        chk("lim_ack1",   64'(cpu_ack_ds_o),   64'h2);
        chk("lim_valid1", 64'(apu_valid_ds_o), 64'h1);
        tick();
        settle();
        chk("lim_ack2",   64'(cpu_ack_ds_o),   64'h2);
        tick();
        set_us(0, 1'b1, 7'h27, 32'hC0DE_0001);
        settle();
        chk("lim_ack3_held", 64'(cpu_ack_ds_o),   64'h0);
        chk("lim_valid3",    64'(apu_valid_ds_o), 64'h0);
        chk("lim_ack_us",    64'(apu_ack_us_o),   64'h1);
        tick();
        apu_req_us_i = '0;
        settle();
        chk("lim_valid_us",  64'(cpu_valid_us_o), 64'h2);
        chk("lim_tag_us",    64'(cpu_tag_us_o[CT +: CT]), 64'h07);
        chk("lim_result",    64'(cpu_result_o[WR +: WR]), 64'hC0DE_0001);
        chk("lim_ack_retire", 64'(cpu_ack_ds_o), 64'h2);
        tick();
        settle();
        chk("lim_drained",   64'(cpu_valid_us_o), 64'h0);
        chk("lim_still_full", 64'(cpu_ack_ds_o),  64'h0);
        do_reset();

        // Two APUs returning to core 2 at once.
        set_us(0, 1'b1, 7'h4A, 32'hAAAA_0000);
        set_us(1, 1'b1, 7'h4B, 32'hBBBB_0000);
        settle();
        chk("con_ack0",   64'(apu_ack_us_o), 64'h1);
        tick();
        apu_req_us_i[0] = 1'b0;
        settle();
        chk("con_valid0", 64'(cpu_valid_us_o), 64'h4);
        chk("con_tag0",   64'(cpu_tag_us_o[2*CT +: CT]), 64'h0A);
        chk("con_res0",   64'(cpu_result_o[2*WR +: WR]), 64'hAAAA_0000);
        chk("con_ack1",   64'(apu_ack_us_o), 64'h2);
        tick();
        apu_req_us_i = '0;
        settle();
        chk("con_valid1", 64'(cpu_valid_us_o), 64'h4);
        chk("con_tag1",   64'(cpu_tag_us_o[2*CT +: CT]), 64'h0B);
        chk("con_res1",   64'(cpu_result_o[2*WR +: WR]), 64'hBBBB_0000);
        tick();
        settle();
        chk("con_empty",  64'(cpu_valid_us_o), 64'h0);
        set_us(0, 1'b1, 7'h4C, 32'hCCCC_0000);
        set_us(1, 1'b1, 7'h4D, 32'hDDDD_0000);
        settle();
        chk("con_wrap",   64'(apu_ack_us_o), 64'h1);
        tick();
        do_reset();

        // Back-pressure on core 3.
        cpu_ready_us_i[3] = 1'b0;
        set_us(0, 1'b1, 7'h71, 32'h1111_1111);
        settle();
        chk("bp_ack0",    64'(apu_ack_us_o), 64'h1);
        tick();
        apu_req_us_i[0] = 1'b0;
        set_us(1, 1'b1, 7'h72, 32'h2222_2222);
        settle();
        chk("bp_valid",   64'(cpu_valid_us_o), 64'h8);
        chk("bp_tag",     64'(cpu_tag_us_o[3*CT +: CT]), 64'h11);
        chk("bp_no_ack",  64'(apu_ack_us_o), 64'h0);
        tick();
        settle();
        chk("bp_hold_res",   64'(cpu_result_o[3*WR +: WR]),   64'h1111_1111);
        chk("bp_hold_flags", 64'(cpu_flags_us_o[3*UF +: UF]), 64'h071);
        chk("bp_hold_valid", 64'(cpu_valid_us_o), 64'h8);
        chk("bp_hold_noack", 64'(apu_ack_us_o), 64'h0);
        cpu_ready_us_i[3] = 1'b1;
        settle();
        chk("bp_release_ack", 64'(apu_ack_us_o), 64'h2);
        tick();
        apu_req_us_i = '0;
        settle();
        chk("bp_next_tag", 64'(cpu_tag_us_o[3*CT +: CT]), 64'h12);
        chk("bp_next_res", 64'(cpu_result_o[3*WR +: WR]), 64'h2222_2222);
        tick();
        settle();
        chk("bp_drained",  64'(cpu_valid_us_o), 64'h0);
        do_reset();

        // Reset while core 0 has two operations in flight.
        cpu_req_ds_i   = 4'b0001;
        apu_ready_ds_i = 2'b11;
        settle();
        chk("mid_ack1", 64'(cpu_ack_ds_o), 64'h1);
        tick();
        settle();
        chk("mid_ack2", 64'(cpu_ack_ds_o), 64'h1);
        tick();
        do_reset();
        set_us(1, 1'b1, 7'h15, 32'h5555_0000);
        settle();
        chk("mid_late_ack", 64'(apu_ack_us_o), 64'h2);
        tick();
        apu_req_us_i = '0;
        settle();
        chk("mid_late_valid", 64'(cpu_valid_us_o), 64'h1);
        chk("mid_late_tag",   64'(cpu_tag_us_o[0 +: CT]), 64'h15);
        chk("mid_late_res",   64'(cpu_result_o[0 +: WR]), 64'h5555_0000);
        tick();
        cpu_req_ds_i   = 4'b0001;
        apu_ready_ds_i = 2'b11;
        settle();
        chk("mid_cnt_a", 64'(cpu_ack_ds_o), 64'h1);
        tick();
        settle();
        chk("mid_cnt_b", 64'(cpu_ack_ds_o), 64'h1);
        tick();
        settle();
        chk("mid_cnt_full", 64'(cpu_ack_ds_o), 64'h0);
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
